// File: rtl/code_loader_pkg.sv
// Shared code-memory geometry and loader framing constants.
package code_loader_pkg;
  localparam int         CODE_ADDR_WIDTH = 13;
  localparam int         CODE_SIZE       = 8192;
  localparam logic [7:0] LOADER_MAGIC    = 8'hB5;
  localparam int         LOADER_TIMEOUT  = 1_000_000;
endpackage

// File: rtl/code_loader.sv
// Parses a framed program image from a byte stream and writes it into code RAM,
// holding the CPU in reset until the image is loaded and its checksum verified.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int WIDTH   = CODE_ADDR_WIDTH,
  parameter int SIZE    = CODE_SIZE,
  parameter int TIMEOUT = LOADER_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [WIDTH-1:0] mem_din_addr,
  output logic [15:0]      mem_din,
  output logic             mem_we,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam int          CW     = WIDTH + 1;
  localparam int          IW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [16:0] SIZE_W = 17'(SIZE);

  state_t          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      hi_q;
  logic [IW-1:0]   idle_q;
  logic            active, expired;

  assign active  = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                   (state_q == S_CHECK);
  // Expiry is judged on the idle count alone, so a byte landing in that cycle is dropped.
  assign expired = active && (idle_q >= IW'(TIMEOUT));
  assign sum_d   = sum_q + rx_data;
  assign cnt_d   = cnt_q + CW'(1);
  assign len_d   = {len_q[15:8], rx_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      hi_q         <= '0;
      idle_q       <= '0;
      mem_we       <= 1'b0;
      mem_din_addr <= '0;
      mem_din      <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (expired) begin
        state_q <= S_ERROR;
        error   <= 1'b1;
        idle_q  <= '0;
      end else if (rx_valid) begin
        idle_q <= '0;
        case (state_q)
          S_IDLE, S_DONE, S_ERROR: begin
            if (rx_data == LOADER_MAGIC) begin
              state_q  <= S_LEN_HI;
              cnt_q    <= '0;
              sum_q    <= '0;
              done     <= 1'b0;
              error    <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
          S_LEN_HI: begin
            len_q   <= {rx_data, 8'h00};
            sum_q   <= sum_d;
            state_q <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_q <= len_d;
            sum_q <= sum_d;
            if ({1'b0, len_d} > SIZE_W) begin
              state_q <= S_ERROR;
              error   <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            hi_q    <= rx_data;
            sum_q   <= sum_d;
            state_q <= S_DATA_LO;
          end
          S_DATA_LO: begin
            mem_we       <= 1'b1;
            mem_din_addr <= cnt_q[WIDTH-1:0];
            mem_din      <= {hi_q, rx_data};
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            state_q      <= (16'(cnt_d) == len_q) ? S_CHECK : S_DATA_HI;
          end
          S_CHECK: begin
            if (rx_data == sum_q) begin
              state_q  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error   <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (active) begin
        idle_q <= idle_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: a frame-level reference model checked every cycle,
// plus literal expectations on the key scenarios.
module tb_code_loader;
  import code_loader_pkg::*;

  localparam int W  = 13;
  localparam int SZ = 8192;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [W-1:0]  mem_din_addr;
  logic [15:0]   mem_din;
  logic          mem_we, cpu_hold, done, error;

  code_loader #(.WIDTH(W), .SIZE(SZ), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_din_addr(mem_din_addr), .mem_din(mem_din), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int dut_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remembers the bytes of the current frame and derives outputs from them.
  bit           in_frame = 0;
  logic [7:0]   fq[$];
  int           idle = 0;
  logic         e_we = 0, e_done = 0, e_err = 0, e_hold = 0;
  logic [15:0]  e_addr = 0, e_din = 0;
  logic [31:0]  wlog[$];

  task automatic eval_frame();
    int n, nw, k, sum;
    n = fq.size();
    if (n < 2) return;
    nw = int'({fq[0], fq[1]});
    if (n == 2) begin
      if (nw > SZ) begin in_frame = 0; e_err = 1; end
      return;
    end
    k = n - 2;
    if (k <= 2 * nw) begin
      if (k % 2 == 0) begin
        e_we   = 1;
        e_addr = 16'(k / 2 - 1);
        e_din  = {fq[n-2], fq[n-1]};
        wlog.push_back({e_addr, e_din});
      end
    end else begin
      sum = 0;
      for (int i = 0; i < n - 1; i++) sum += int'(fq[i]);
      in_frame = 0;
      if (8'(sum) == fq[n-1]) begin e_done = 1; e_hold = 0; end
      else e_err = 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        in_frame = 0; fq.delete(); idle = 0;
        e_we = 0; e_done = 0; e_err = 0; e_hold = 0; e_addr = 0; e_din = 0;
      end else begin
        e_we = 0;
        if (in_frame && idle >= TO) begin
          in_frame = 0; e_err = 1; idle = 0;
        end else if (rx_valid) begin
          idle = 0;
          if (!in_frame) begin
            if (rx_data == 8'hB5) begin
              in_frame = 1; fq.delete(); e_done = 0; e_err = 0; e_hold = 1;
            end
          end else begin
            fq.push_back(rx_data);
            eval_frame();
          end
        end else if (in_frame) begin
          idle++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("done", 32'(done), 32'(e_done));
      check("error", 32'(error), 32'(e_err));
      check("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      if (e_we) begin
        check("mem_addr", 32'(mem_din_addr), 32'(e_addr));
        check("mem_din", 32'(mem_din), 32'(e_din));
      end
      if (mem_we) dut_we++;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame1(input logic [7:0] chk);
    send(8'hB5);
    check("hold_rise", 32'(cpu_hold), 32'd1);
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(chk);
    gap(2);
  endtask

  int base;
  int sum;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(mem_din_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);

    send(8'h11); send(8'h22); gap(3);
    check("idle_hold", 32'(cpu_hold), 32'd0);
    check("idle_we", 32'(dut_we), 32'd0);
    check("idle_din", 32'(mem_din), 32'd0);

    send_frame1(8'hC0);
    check("f1_done", 32'(done), 32'd1);
    check("f1_hold", 32'(cpu_hold), 32'd0);
    check("f1_nlog", 32'(wlog.size()), 32'd2);
    check("f1_w0", wlog[0], {16'h0000, 16'h1234});
    check("f1_w1", wlog[1], {16'h0001, 16'hABCD});
    check("f1_nwe", 32'(dut_we), 32'd2);

    send_frame1(8'hC1);
    check("bad_err", 32'(error), 32'd1);
    check("bad_hold", 32'(cpu_hold), 32'd1);
    check("bad_nwe", 32'(dut_we), 32'd4);
    send_frame1(8'hC0);
    check("rec_done", 32'(done), 32'd1);
    check("rec_err", 32'(error), 32'd0);

    base = dut_we;
    send(8'hB5); send(8'h20); send(8'h01); gap(3);
    check("big_err", 32'(error), 32'd1);
    check("big_hold", 32'(cpu_hold), 32'd1);
    check("big_nwe", 32'(dut_we), 32'(base));

    send(8'hB5); send(8'h00); send(8'h00); send(8'h00); gap(2);
    check("zero_done", 32'(done), 32'd1);
    check("zero_nwe", 32'(dut_we), 32'(base));

    send(8'hB5); send(8'h00); send(8'h01); send(8'h12); gap(TO + 5);
    check("to_err", 32'(error), 32'd1);
    check("to_hold", 32'(cpu_hold), 32'd1);

    send(8'hB5); send(8'h00); send(8'h01); send(8'h12); gap(TO);
    send(8'h34); send(8'h47); gap(2);
    check("race_err", 32'(error), 32'd1);
    check("race_nwe", 32'(dut_we), 32'(base));

    base = dut_we;
    send(8'hB5); send(8'h00); send(8'h0A);
    for (int i = 0; i < 3; i++) begin send(8'(2 * i + 1)); send(8'(2 * i + 2)); end
    @(posedge clk); #2 reset = 1'b1; #1;
    check("mid_hold", 32'(cpu_hold), 32'd0);
    check("mid_we", 32'(mem_we), 32'd0);
    check("mid_addr", 32'(mem_din_addr), 32'd0);
    check("mid_din", 32'(mem_din), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send(8'h07); send(8'h08); gap(3);
    check("mid_nwe", 32'(dut_we), 32'(base + 3));

    base = dut_we;
    sum = 8'h20;
    send(8'hB5); send(8'h20); send(8'h00);
    for (int i = 0; i < SZ; i++) begin
      send(8'(i >> 8)); send(8'(i));
      sum += (i >> 8) + (i & 255);
    end
    send(8'(sum)); gap(2);
    check("full_done", 32'(done), 32'd1);
    check("full_nwe", 32'(dut_we), 32'(base + SZ));
    check("full_last", wlog[wlog.size()-1], {16'h1FFF, 16'h1FFF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
